// File: rtl/div_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_share_ctrl
// Purpose  : Round-robin arbiter and sequencer sharing one iterative 32-bit
//            divider among NUM_REQ requesters. One transaction is in flight
//            at a time; results are returned with the winner's ID over a
//            held response channel.
// Options  : DIV_ZERO_BYPASS_EN - zero-divisor requests skip the divider and
//            respond the cycle after accept.
// Revision : 1.0 - initial release
// ============================================================================
module div_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_dividend,
    input  logic [NUM_REQ*32-1:0]  req_divisor,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_quotient,
    output logic [31:0]            rsp_remainder,
    output logic                   rsp_error,
    input  logic                   rsp_ready,
    output logic                   div_start,
    output logic [31:0]            div_dividend,
    output logic [31:0]            div_divisor,
    input  logic                   div_rdy,
    input  logic [31:0]            div_quotient,
    input  logic [31:0]            div_remainder,
    output logic                   busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]      r_state;
    logic [ID_W-1:0] r_rr;
    logic [ID_W-1:0] r_grant;
    logic [31:0]     r_dividend;
    logic [31:0]     r_divisor;
    logic [31:0]     r_quotient;
    logic [31:0]     r_remainder;
    logic            r_error;

    logic            w_found;
    logic            w_hi_found;
    logic [ID_W-1:0] w_hi_idx;
    logic [ID_W-1:0] w_lo_idx;
    logic [ID_W-1:0] w_gnt;
    logic [31:0]     w_sel_dividend;
    logic [31:0]     w_sel_divisor;
    logic [ID_W-1:0] w_rr_next;

    // Round-robin search: lowest valid index at or above the pointer wins,
    // otherwise the lowest valid index overall (wrap-around).
    always_comb begin
        w_found    = 1'b0;
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_found  = 1'b1;
                w_lo_idx = ID_W'(i);
                if (i >= int'(r_rr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = ID_W'(i);
                end
            end
        end
        w_gnt = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    // Operand mux for the requester currently being granted.
    always_comb begin
        w_sel_dividend = '0;
        w_sel_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_gnt) begin
                w_sel_dividend = req_dividend[32*i +: 32];
                w_sel_divisor  = req_divisor[32*i +: 32];
            end
        end
    end

    assign w_rr_next = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + ID_W'(1);

    // Transaction sequencer: accept, start divider, wait, capture, respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_grant     <= '0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_gnt;
                        r_dividend <= w_sel_dividend;
                        r_divisor  <= w_sel_divisor;
                        r_error    <= (w_sel_divisor == 32'd0);
`ifdef DIV_ZERO_BYPASS_EN
                        if (w_sel_divisor == 32'd0) begin
                            // Result of a divide-by-zero is known up front.
                            r_quotient  <= 32'hFFFF_FFFF;
                            r_remainder <= w_sel_dividend;
                            r_state     <= S_RESP;
                        end else begin
                            r_state <= S_LOAD;
                        end
`else
                        r_state <= S_LOAD;
`endif
                    end
                end
                S_LOAD: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (div_rdy) begin
                        r_quotient  <= div_quotient;
                        r_remainder <= div_remainder;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rr    <= w_rr_next;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Divider start level: one pulse in LOAD, then held while the divider is
    // busy so it is dropped in the very cycle div_rdy returns (no reload).
    always_comb begin
        div_start = 1'b0;
        case (r_state)
            S_LOAD:  div_start = 1'b1;
            S_RUN:   div_start = ~div_rdy;
            default: div_start = 1'b0;
        endcase
    end

    assign req_ready     = (r_state == S_IDLE && w_found && !reset)
                           ? (NUM_REQ'(1) << w_gnt) : '0;
    assign rsp_valid     = (r_state == S_RESP);
    assign rsp_id        = r_grant;
    assign rsp_quotient  = r_quotient;
    assign rsp_remainder = r_remainder;
    assign rsp_error     = r_error;
    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_share_ctrl
// Purpose  : Scoreboard bench for div_share_ctrl with a behavioural iterative
//            divider model and a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_share_ctrl;

    localparam int N = 4;
`ifdef DIV_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 35;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*32-1:0]   req_dividend;
    logic [N*32-1:0]   req_divisor;
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_quotient;
    logic [31:0]       rsp_remainder;
    logic              rsp_error;
    logic              rsp_ready;
    logic              div_start;
    logic [31:0]       div_dividend;
    logic [31:0]       div_divisor;
    logic              div_rdy;
    logic [31:0]       div_quotient;
    logic [31:0]       div_remainder;
    logic              busy;

    div_share_ctrl #(.NUM_REQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
        .rsp_remainder(rsp_remainder), .rsp_error(rsp_error), .rsp_ready(rsp_ready),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_rdy(div_rdy), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Iterative divider model: samples on start while idle, 32 busy cycles.
    logic [31:0] m_a, m_b;
    int          m_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            div_rdy <= 1'b1; m_cnt <= 0; m_a <= '0; m_b <= '0;
            div_quotient <= '0; div_remainder <= '0;
        end else if (div_rdy && div_start) begin
            div_rdy <= 1'b0; m_cnt <= 0; m_a <= div_dividend; m_b <= div_divisor;
        end else if (!div_rdy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 31) begin
                div_rdy       <= 1'b1;
                div_quotient  <= (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
                div_remainder <= (m_b == 0) ? m_a : m_a % m_b;
            end
        end
    end

    typedef struct {
        int          id;
        logic [31:0] q;
        logic [31:0] r;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_q[$];
    int   ncmp = 0;
    int   nfail = 0;
    int   mptr = 0;
    int   mode = 0;
    int   rsp_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.id = id;
        if (b == 0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.err = 1'b1; e.lat = ZLAT;
        end else begin
            e.q = a / b; e.r = a % b; e.err = 1'b0; e.lat = 35;
        end
        return e;
    endfunction

    // Response-ready driver: 0 = always ready, 1 = random, 2 = stall 10 cycles.
    int stall = 0;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (rsp_valid) begin stall++; rsp_ready = (stall > 10); end
                    else begin stall = 0; rsp_ready = 1'b0; end
                end
            endcase
        end
    end

    // Monitor: grants, divider handshake and responses against the scoreboard.
    initial begin
        exp_t        cur;
        bit          rsp_seen = 0;
        int          rsp_len = 0;
        int          accept_cyc = 0;
        logic        prev_rdy = 1'b1;
        logic [3:0]  onehot;
        forever begin
            @(negedge clk);
            if (reset) begin
                rsp_seen = 0; rsp_len = 0; prev_rdy = 1'b1;
            end else begin
                if (busy) chk("no_ready_while_busy", 64'(req_ready), 64'd0);
                if (req_ready != 0) begin
                    if (gnt_q.size() == 0) chk("unexpected_grant", 64'(req_ready), 64'd0);
                    else begin
                        onehot = 4'b0001 << gnt_q.pop_front();
                        chk("grant", 64'(req_ready), 64'(onehot));
                    end
                    accept_cyc = cyc;
                end
                if (!prev_rdy && div_rdy) chk("start_when_rdy_returns", 64'(div_start), 64'd0);
                prev_rdy = div_rdy;
                if (rsp_valid) begin
                    if (!rsp_seen) begin
                        if (exp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
                        else begin
                            cur = exp_q.pop_front();
                            rsp_seen = 1;
                            chk("latency", 64'(cyc - accept_cyc), 64'(cur.lat));
                        end
                    end
                    if (rsp_seen) begin
                        chk("rsp_id", 64'(rsp_id), 64'(cur.id));
                        chk("rsp_quotient", 64'(rsp_quotient), 64'(cur.q));
                        chk("rsp_remainder", 64'(rsp_remainder), 64'(cur.r));
                        chk("rsp_error", 64'(rsp_error), 64'(cur.err));
                    end
                    rsp_len++;
                    if (rsp_ready) begin
                        if (mode == 0) chk("rsp_one_cycle", 64'(rsp_len), 64'd1);
                        rsp_done++; rsp_seen = 0; rsp_len = 0;
                    end
                end
            end
        end
    end

    task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
        req_dividend[32*id +: 32] = a;
        req_divisor[32*id +: 32]  = b;
    endtask

    task automatic do_reset(input bit check);
        reset = 1'b1;
        gnt_q.delete(); exp_q.delete();
        mptr = 0;
        @(negedge clk);
        if (check) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_id", 64'(rsp_id), 64'd0);
            chk("rst_rsp_q", 64'(rsp_quotient), 64'd0);
            chk("rst_rsp_r", 64'(rsp_remainder), 64'd0);
            chk("rst_rsp_err", 64'(rsp_error), 64'd0);
            chk("rst_div_start", 64'(div_start), 64'd0);
            chk("rst_div_ops", {div_dividend, div_divisor}, 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issue a batch of simultaneous requests; the reference model predicts
    // the grant order by rotating from the last-served requester.
    task automatic run_batch(input logic [3:0] mask, input int m);
        int         target;
        int         guard;
        int         id;
        logic [3:0] acc;
        mode = m;
        target = rsp_done;
        for (int k = 0; k < N; k++) begin
            id = (mptr + k) % N;
            if (mask[id]) begin
                gnt_q.push_back(id);
                exp_q.push_back(model(id, req_dividend[32*id +: 32], req_divisor[32*id +: 32]));
                target++;
            end
        end
        for (int k = 0, last = -1; k < N; k++) begin
            id = (mptr + k) % N;
            if (mask[id]) last = id;
            if (k == N - 1 && last >= 0) mptr = (last + 1) % N;
        end
        acc = '0;
        guard = 0;
        req_valid = mask;
        while (rsp_done < target && guard < 600) begin
            @(negedge clk);
            acc = acc | req_ready;
            @(posedge clk); #1;
            req_valid = mask & ~acc;
            guard++;
        end
        req_valid = '0;
        if (rsp_done < target) chk("batch_timeout", 64'(rsp_done), 64'(target));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0]  mask;
        logic [31:0] b;
        int          g;
        logic [3:0]  acc;
        reset = 1'b1;
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;
        do_reset(1);

        // Single request from requester 2: 100 / 7.
        set_ops(2, 32'd100, 32'd7);
        run_batch(4'b0100, 0);

        // All four at once after a fresh reset: order 0,1,2,3.
        do_reset(0);
        for (int i = 0; i < N; i++) set_ops(i, $urandom, 32'($urandom_range(1, 1000)));
        run_batch(4'b1111, 0);

        // Requesters 1 and 3 re-request: 1,3,1,3.
        for (int rep = 0; rep < 2; rep++) begin
            set_ops(1, $urandom, 32'($urandom_range(1, 50)));
            set_ops(3, $urandom, $urandom);
            run_batch(4'b1010, 1);
        end

        // Divide by zero.
        set_ops(0, 32'hFFFF_FFFF, 32'd0);
        run_batch(4'b0001, 0);

        // Response held off for 10 cycles with another requester pending.
        set_ops(0, $urandom, 32'($urandom_range(1, 9)));
        set_ops(2, $urandom, 32'd0);
        run_batch(4'b0101, 2);

        // Randomised batches, occasional zero divisors.
        for (int t = 0; t < 12; t++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 7))
                    0:       b = 32'd0;
                    1, 2, 3: b = 32'($urandom_range(1, 255));
                    default: b = $urandom;
                endcase
                set_ops(i, $urandom, b);
            end
            run_batch(mask, int'($urandom_range(0, 1)));
        end

        // Reset in the middle of a divide, then a normal 9 / 3.
        set_ops(2, $urandom, 32'($urandom_range(1, 100)));
        gnt_q.push_back(2);
        exp_q.push_back(model(2, req_dividend[95:64], req_divisor[95:64]));
        mode = 0;
        req_valid = 4'b0100;
        acc = '0;
        g = 0;
        while (acc == 0 && g < 10) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1; g++;
        end
        req_valid = '0;
        chk("midrst_accept", 64'(acc), 64'h4);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_busy", 64'(busy), 64'd1);
        do_reset(1);
        set_ops(3, 32'd9, 32'd3);
        run_batch(4'b1000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
